collision_engine: RTL and testbench

- Time-multiplexed collision resolver for the bowling simulation. It is the parametrised successor to the per-frame collision check.
- Accepts one frame snapshot of ball and N_PINS pin states. Scans ball-pin pairs, then every pin-pin pair, one pair per clock, using a single shared distance/velocity datapath.
- Returns updated ball velocity, pin velocities and hit flags with a done pulse. Sits between the physics integrator and the pin state registers.

---
 rtl/collision_engine.sv | 256 +++++++++++++++++++++++++
 tb/tb_collision_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_engine.sv
`default_nettype none
// ============================================================================
// Module   : collision_engine
// Brief    : Time-multiplexed ball/pin and pin/pin collision resolver that
//            runs every pair through one shared distance/velocity datapath.
// Revision : 1.0
// ============================================================================
module collision_engine #(
    parameter int N_PINS      = 10,
    parameter int W           = 16,
    parameter int BALL_MASS   = 7200,
    parameter int PIN_MASS    = 1000,
    parameter int BALL_RADIUS = 100,
    parameter int PIN_RADIUS  = 25
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [W-1:0]        ball_x_in,
    input  logic [W-1:0]        ball_y_in,
    input  logic [W-1:0]        ball_vx_in,
    input  logic [W-1:0]        ball_vy_in,
    input  logic [N_PINS*W-1:0] pins_x_in,
    input  logic [N_PINS*W-1:0] pins_y_in,
    input  logic [N_PINS*W-1:0] pins_vx_in,
    input  logic [N_PINS*W-1:0] pins_vy_in,
    input  logic [N_PINS-1:0]   pins_hit_in,
    output logic [W-1:0]        ball_vx_out,
    output logic [W-1:0]        ball_vy_out,
    output logic [N_PINS*W-1:0] pins_vx_out,
    output logic [N_PINS*W-1:0] pins_vy_out,
    output logic [N_PINS-1:0]   pins_hit_out,
    output logic                done_out
);

    localparam int IW = (N_PINS > 1) ? $clog2(N_PINS) : 1;
    localparam int DW = 2*W + 3;
    localparam int KW = 11;
    localparam int PW = W + KW + 1;

    localparam int S      = BALL_MASS + PIN_MASS;
    localparam int K_BB_I = (256*(BALL_MASS - PIN_MASS) + S/2) / S;
    localparam int K_BP_I = (512*PIN_MASS + S/2) / S;
    localparam int K_PB_I = (512*BALL_MASS + S/2) / S;

    localparam logic signed [KW-1:0] K_BB = KW'(K_BB_I);
    localparam logic signed [KW-1:0] K_BP = KW'(K_BP_I);
    localparam logic signed [KW-1:0] K_PB = KW'(K_PB_I);
    localparam logic signed [KW-1:0] K_PP = KW'(-K_BB_I);

    localparam logic [DW-1:0] R_BP = DW'((BALL_RADIUS + PIN_RADIUS) * (BALL_RADIUS + PIN_RADIUS));
    localparam logic [DW-1:0] R_PP = DW'((2*PIN_RADIUS) * (2*PIN_RADIUS));

    localparam logic [IW-1:0] LAST  = IW'(N_PINS - 1);
    localparam logic [IW-1:0] LAST2 = IW'(N_PINS - 2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BALL_SCAN = 2'd1,
        PIN_SCAN  = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t state;
    logic   ready;
    logic   done;
    logic [IW-1:0] pi;
    logic [IW-1:0] pj;

    // Working copy of the frame, updated one pair per clock
    logic signed [W-1:0] bx, by, bvx, bvy;
    logic signed [W-1:0] px  [N_PINS];
    logic signed [W-1:0] py  [N_PINS];
    logic signed [W-1:0] pvx [N_PINS];
    logic signed [W-1:0] pvy [N_PINS];
    logic [N_PINS-1:0]   hit;

    logic signed [W-1:0] n_bvx, n_bvy;
    logic signed [W-1:0] n_pvx [N_PINS];
    logic signed [W-1:0] n_pvy [N_PINS];
    logic [N_PINS-1:0]   n_hit;

    logic signed [W-1:0] o_bvx, o_bvy;
    logic signed [W-1:0] o_pvx [N_PINS];
    logic signed [W-1:0] o_pvy [N_PINS];
    logic [N_PINS-1:0]   o_hit;

    logic signed [W-1:0] op_ax, op_ay, op_bx, op_by;
    logic [DW-1:0]       d2;

    function automatic logic [DW-1:0] dist2(
        input logic signed [W-1:0] ax,
        input logic signed [W-1:0] ay,
        input logic signed [W-1:0] cx,
        input logic signed [W-1:0] cy
    );
        logic signed [W:0]    dx, dy;
        logic signed [DW-1:0] ex, ey;
        dx = {ax[W-1], ax} - {cx[W-1], cx};
        dy = {ay[W-1], ay} - {cy[W-1], cy};
        ex = {{(DW-W-1){dx[W]}}, dx};
        ey = {{(DW-W-1){dy[W]}}, dy};
        dist2 = $unsigned(ex*ex + ey*ey);
    endfunction

    // (ka*va + kb*vb) >>> 8, clamped to the W-bit signed range
    function automatic logic signed [W-1:0] mix(
        input logic signed [W-1:0]  va,
        input logic signed [W-1:0]  vb,
        input logic signed [KW-1:0] ka,
        input logic signed [KW-1:0] kb
    );
        logic signed [PW-1:0] s, sh;
        s  = {{(PW-KW){ka[KW-1]}}, ka} * {{(PW-W){va[W-1]}}, va}
           + {{(PW-KW){kb[KW-1]}}, kb} * {{(PW-W){vb[W-1]}}, vb};
        sh = s >>> 8;
        if (!sh[PW-1] && (|sh[PW-2:W-1]))
            mix = {1'b0, {(W-1){1'b1}}};
        else if (sh[PW-1] && !(&sh[PW-2:W-1]))
            mix = {1'b1, {(W-1){1'b0}}};
        else
            mix = sh[W-1:0];
    endfunction

    assign op_ax = (state == PIN_SCAN) ? px[pi] : bx;
    assign op_ay = (state == PIN_SCAN) ? py[pi] : by;
    assign op_bx = (state == PIN_SCAN) ? px[pj] : px[pi];
    assign op_by = (state == PIN_SCAN) ? py[pj] : py[pi];
    assign d2    = dist2(op_ax, op_ay, op_bx, op_by);

    always_comb begin
        n_bvx = bvx;
        n_bvy = bvy;
        n_pvx = pvx;
        n_pvy = pvy;
        n_hit = hit;
        if (state == BALL_SCAN && !hit[pi] && d2 <= R_BP) begin
            n_bvx     = mix(bvx, pvx[pi], K_BB, K_BP);
            n_bvy     = mix(bvy, pvy[pi], K_BB, K_BP);
            n_pvx[pi] = mix(bvx, pvx[pi], K_PB, K_PP);
            n_pvy[pi] = mix(bvy, pvy[pi], K_PB, K_PP);
            n_hit[pi] = 1'b1;
        end else if (state == PIN_SCAN && (hit[pi] ^ hit[pj]) && d2 <= R_PP) begin
            n_pvx[pi] = pvx[pj];
            n_pvy[pi] = pvy[pj];
            n_pvx[pj] = pvx[pi];
            n_pvy[pj] = pvy[pi];
            n_hit[pi] = 1'b1;
            n_hit[pj] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            pi    <= '0;
            pj    <= '0;
            bx    <= '0;
            by    <= '0;
            bvx   <= '0;
            bvy   <= '0;
            hit   <= '0;
            o_bvx <= '0;
            o_bvy <= '0;
            o_hit <= '0;
            for (int k = 0; k < N_PINS; k++) begin
                px[k]    <= '0;
                py[k]    <= '0;
                pvx[k]   <= '0;
                pvy[k]   <= '0;
                o_pvx[k] <= '0;
                o_pvy[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        bx    <= ball_x_in;
                        by    <= ball_y_in;
                        bvx   <= ball_vx_in;
                        bvy   <= ball_vy_in;
                        hit   <= pins_hit_in;
                        for (int k = 0; k < N_PINS; k++) begin
                            px[k]  <= pins_x_in[k*W +: W];
                            py[k]  <= pins_y_in[k*W +: W];
                            pvx[k] <= pins_vx_in[k*W +: W];
                            pvy[k] <= pins_vy_in[k*W +: W];
                        end
                        pi    <= '0;
                        ready <= 1'b0;
                        state <= BALL_SCAN;
                    end
                end
                BALL_SCAN: begin
                    bvx <= n_bvx;
                    bvy <= n_bvy;
                    pvx <= n_pvx;
                    pvy <= n_pvy;
                    hit <= n_hit;
                    if (pi == LAST) begin
                        pi    <= '0;
                        pj    <= IW'(1);
                        state <= PIN_SCAN;
                    end else begin
                        pi <= pi + 1'b1;
                    end
                end
                PIN_SCAN: begin
                    pvx <= n_pvx;
                    pvy <= n_pvy;
                    hit <= n_hit;
                    if (pj == LAST && pi == LAST2) begin
                        // Final pair: outputs take the post-update values directly
                        o_bvx <= bvx;
                        o_bvy <= bvy;
                        o_pvx <= n_pvx;
                        o_pvy <= n_pvy;
                        o_hit <= n_hit;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (pj == LAST) begin
                        pi <= pi + 1'b1;
                        pj <= pi + IW'(2);
                    end else begin
                        pj <= pj + 1'b1;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready_out    = ready;
    assign done_out     = done;
    assign ball_vx_out  = o_bvx;
    assign ball_vy_out  = o_bvy;
    assign pins_hit_out = o_hit;

    for (genvar k = 0; k < N_PINS; k++) begin : g_out
        assign pins_vx_out[k*W +: W] = o_pvx[k];
        assign pins_vy_out[k*W +: W] = o_pvy[k];
    end

endmodule
`default_nettype wire

// File: tb/tb_collision_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_collision_engine
// Brief    : Directed self-checking bench for collision_engine (10 and 3 pins).
// Revision : 1.0
// ============================================================================
module tb_collision_engine;

    localparam int N  = 10;
    localparam int N3 = 3;
    localparam int W  = 16;

    logic clk;
    logic rst;
    logic valid;
    logic ready;
    logic done;
    logic [W-1:0]   ball_x, ball_y, ball_vx, ball_vy;
    logic [N*W-1:0] pins_x, pins_y, pins_vx, pins_vy;
    logic [N-1:0]   hit_in;
    logic [W-1:0]   ob_vx, ob_vy;
    logic [N*W-1:0] op_vx, op_vy;
    logic [N-1:0]   o_hit;

    logic valid3;
    logic ready3;
    logic done3;
    logic [N3*W-1:0] p3_x, p3_y, p3_vx, p3_vy;
    logic [N3-1:0]   hit3_in;
    logic [W-1:0]    ob3_vx, ob3_vy;
    logic [N3*W-1:0] op3_vx, op3_vy;
    logic [N3-1:0]   o3_hit;

    logic [W-1:0] tpx  [N];
    logic [W-1:0] tpy  [N];
    logic [W-1:0] tpvx [N];
    logic [W-1:0] tpvy [N];

    int checks   = 0;
    int failures = 0;
    int lat;
    int pulses;

    collision_engine #(.N_PINS(N)) dut (
        .clk_in(clk), .rst_in(rst), .valid_in(valid), .ready_out(ready),
        .ball_x_in(ball_x), .ball_y_in(ball_y), .ball_vx_in(ball_vx), .ball_vy_in(ball_vy),
        .pins_x_in(pins_x), .pins_y_in(pins_y), .pins_vx_in(pins_vx), .pins_vy_in(pins_vy),
        .pins_hit_in(hit_in),
        .ball_vx_out(ob_vx), .ball_vy_out(ob_vy),
        .pins_vx_out(op_vx), .pins_vy_out(op_vy),
        .pins_hit_out(o_hit), .done_out(done)
    );

    collision_engine #(.N_PINS(N3)) dut3 (
        .clk_in(clk), .rst_in(rst), .valid_in(valid3), .ready_out(ready3),
        .ball_x_in(ball_x), .ball_y_in(ball_y), .ball_vx_in(ball_vx), .ball_vy_in(ball_vy),
        .pins_x_in(p3_x), .pins_y_in(p3_y), .pins_vx_in(p3_vx), .pins_vy_in(p3_vy),
        .pins_hit_in(hit3_in),
        .ball_vx_out(ob3_vx), .ball_vy_out(ob3_vy),
        .pins_vx_out(op3_vx), .pins_vy_out(op3_vy),
        .pins_hit_out(o3_hit), .done_out(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic pack();
        for (int k = 0; k < N; k++) begin
            pins_x[k*W +: W]  = tpx[k];
            pins_y[k*W +: W]  = tpy[k];
            pins_vx[k*W +: W] = tpvx[k];
            pins_vy[k*W +: W] = tpvy[k];
        end
    endtask

    task automatic set_default();
        ball_x  = 16'd0;
        ball_y  = 16'd0;
        ball_vx = 16'd100;
        ball_vy = 16'd0;
        hit_in  = '0;
        for (int k = 0; k < N; k++) begin
            tpx[k]  = 16'd10000;
            tpy[k]  = 16'd10000;
            tpvx[k] = 16'd0;
            tpvy[k] = 16'd0;
        end
        tpx[0] = 16'd100;
        tpy[0] = 16'd0;
        pack();
    endtask

    // Called #1 after a rising edge; returns edges from acceptance to done_out
    task automatic frame(output int n);
        int guard;
        guard = 0;
        while (!ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid   = 1'b0;
        valid3  = 1'b0;
        hit3_in = '0;
        p3_x    = '0;
        p3_y    = '0;
        p3_vx   = '0;
        p3_vy   = '0;
        set_default();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ball_vx", 32'(ob_vx), 32'd0);
        check("reset_hit", 32'(o_hit), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single head-on hit
        set_default();
        frame(lat);
        check("basic_latency", 32'(lat), 32'd55);
        check("basic_ball_vx", 32'(ob_vx), 32'd75);
        check("basic_ball_vy", 32'(ob_vy), 32'd0);
        check("basic_pin0_vx", 32'(op_vx[0 +: W]), 32'd175);
        check("basic_pin0_vy", 32'(op_vy[0 +: W]), 32'd0);
        check("basic_hit", 32'(o_hit), 32'h001);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);

        // Chain reaction pin0 -> pin1
        set_default();
        tpx[1] = 16'd140;
        tpy[1] = 16'd0;
        pack();
        frame(lat);
        check("chain_pin1_vx", 32'(op_vx[W +: W]), 32'd175);
        check("chain_pin0_vx", 32'(op_vx[0 +: W]), 32'd0);
        check("chain_ball_vx", 32'(ob_vx), 32'd75);
        check("chain_hit", 32'(o_hit), 32'h003);

        // Distance boundary: equality collides
        set_default();
        tpx[0] = 16'd125;
        pack();
        frame(lat);
        check("edge125_hit", 32'(o_hit), 32'h001);
        check("edge125_ball_vx", 32'(ob_vx), 32'd75);
        set_default();
        tpx[0] = 16'd126;
        pack();
        frame(lat);
        check("edge126_hit", 32'(o_hit), 32'h000);
        check("edge126_ball_vx", 32'(ob_vx), 32'd100);
        check("edge126_pin0_vx", 32'(op_vx[0 +: W]), 32'd0);

        // Saturation of the pin result
        set_default();
        ball_vx = 16'd32767;
        frame(lat);
        check("sat_pin0_vx", 32'(op_vx[0 +: W]), 32'd32767);
        check("sat_ball_vx", 32'(ob_vx), 32'd24831);

        // Already-hit pin is skipped by the ball
        set_default();
        hit_in  = 10'h001;
        tpvx[0] = 16'd50;
        pack();
        frame(lat);
        check("prehit_ball_vx", 32'(ob_vx), 32'd100);
        check("prehit_pin0_vx", 32'(op_vx[0 +: W]), 32'd50);
        check("prehit_hit", 32'(o_hit), 32'h001);

        // Reset during scan aborts the frame
        set_default();
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ball_vx", 32'(ob_vx), 32'd0);
        check("abort_pin0_vx", 32'(op_vx[0 +: W]), 32'd0);
        check("abort_hit", 32'(o_hit), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", 32'(ready), 32'd1);
        pulses = 0;
        for (int c = 0; c < 70; c++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 32'(pulses), 32'd0);

        // valid held through the scan: inputs changed mid-scan must not be relatched
        set_default();
        valid = 1'b1;
        @(posedge clk); #1;
        ball_vx = 16'd500;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_latency", 32'(lat), 32'd55);
        check("hold_ball_vx", 32'(ob_vx), 32'd75);
        lat = 0;
        @(posedge clk); #1;
        lat++;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        valid = 1'b0;
        check("hold_period", 32'(lat), 32'd57);
        check("hold2_ball_vx", 32'(ob_vx), 32'd378);
        check("hold2_pin0_vx", 32'(op_vx[0 +: W]), 32'd878);

        // Three-pin instance
        set_default();
        p3_x  = {16'd10000, 16'd10000, 16'd100};
        p3_y  = {16'd10000, 16'd10000, 16'd0};
        p3_vx = '0;
        p3_vy = '0;
        valid3 = 1'b1;
        @(posedge clk); #1;
        valid3 = 1'b0;
        lat = 0;
        while (!done3 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n3_latency", 32'(lat), 32'd6);
        check("n3_ball_vx", 32'(ob3_vx), 32'd75);
        check("n3_pin0_vx", 32'(op3_vx[0 +: W]), 32'd175);
        check("n3_hit", 32'(o3_hit), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
